if_stage: RTL

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage_if.sv | 26 ++
 rtl/if_stage.sv | 115 +++++++++++
 2 files changed

// File: rtl/if_stage_if.sv
// Bundles the fetch stage's hazard/redirect inputs, its instruction-memory
// handshake and the IF_ID outputs. The master modport is the fetch stage;
// the slave modport is the environment around it: hazard unit, branch unit,
// instruction memory and the IF_ID register.
interface if_stage_if;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] if_inst;
   logic [31:0] if_pc_4;
   logic        if_valid;

   modport master (
      input  stall, redirect, redirect_pc, imem_ready, imem_rdata,
      output imem_req, imem_addr, if_inst, if_pc_4, if_valid
   );

   modport slave (
      output stall, redirect, redirect_pc, imem_ready, imem_rdata,
      input  imem_req, imem_addr, if_inst, if_pc_4, if_valid
   );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage. It keeps one request in flight against a
// variable-latency instruction memory. A response that the consumer cannot
// take is buffered. A response that a redirect has killed is drained.
//
// state | meaning
// ------+----------------------------------------------------------------
// FETCH | request at pc outstanding; a response is presented directly
// HOLD  | response parked in inst_buf while stalled; no request issued
// DRAIN | killed request at req_addr still in flight; its response is dropped
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input logic        clk,
   input logic        rst,
   if_stage_if.master bus
);

   typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;

   localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & ~32'h3;

   state_t      state, state_nxt;
   logic [31:0] pc, pc_nxt;
   logic [31:0] inst_buf, inst_buf_nxt;
   logic [31:0] req_addr, req_addr_nxt;
   logic [31:0] target;
   logic        valid;

   // The low two bits of the redirect target are discarded so pc stays word aligned.
   assign target = bus.redirect_pc & ~32'h3;

   // State register; reset takes precedence over stall and redirect.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= FETCH;
         pc       <= RESET_PC_ALIGNED;
         inst_buf <= 32'h0;
         req_addr <= 32'h0;
      end else begin
         state    <= state_nxt;
         pc       <= pc_nxt;
         inst_buf <= inst_buf_nxt;
         req_addr <= req_addr_nxt;
      end
   end

   // Next-state logic; a redirect wins over a stall in every state.
   always_comb begin
      state_nxt    = state;
      pc_nxt       = pc;
      inst_buf_nxt = inst_buf;
      req_addr_nxt = req_addr;
      case (state)
         FETCH: begin
            if (bus.redirect) begin
               pc_nxt = target;
               if (!bus.imem_ready) begin
                  req_addr_nxt = pc;
                  state_nxt    = DRAIN;
               end
            end else if (bus.imem_ready) begin
               if (bus.stall) begin
                  inst_buf_nxt = bus.imem_rdata;
                  state_nxt    = HOLD;
               end else begin
                  pc_nxt = pc + 32'd4;
               end
            end
         end
         HOLD: begin
            if (bus.redirect) begin
               pc_nxt    = target;
               state_nxt = FETCH;
            end else if (!bus.stall) begin
               pc_nxt    = pc + 32'd4;
               state_nxt = FETCH;
            end
         end
         DRAIN: begin
            if (bus.redirect) pc_nxt = target;
            if (bus.imem_ready) state_nxt = FETCH;
         end
         default: state_nxt = FETCH;
      endcase
   end

   // Outputs; if_inst is forced to zero whenever if_valid is low.
   always_comb begin
      bus.imem_req  = 1'b0;
      bus.imem_addr = pc;
      bus.if_inst   = 32'h0;
      bus.if_pc_4   = pc + 32'd4;
      valid         = 1'b0;
      if (!rst) begin
         case (state)
            FETCH: begin
               bus.imem_req = 1'b1;
               valid        = bus.imem_ready & ~bus.redirect;
               if (valid) bus.if_inst = bus.imem_rdata;
            end
            HOLD: begin
               valid = ~bus.redirect;
               if (valid) bus.if_inst = inst_buf;
            end
            DRAIN: begin
               bus.imem_req  = 1'b1;
               bus.imem_addr = req_addr;
            end
            default: valid = 1'b0;
         endcase
      end
      bus.if_valid = valid;
   end

endmodule
